// File: rtl/gated_counter_sched_pkg.sv
// -----------------------------------------------------------------------------
// gated_counter_sched_pkg
// Shared types and widths for the gated counter scheduler.
//   sched_state_e : controller state encoding (also exported on state_o)
//   TIMER_W       : width of the wake and idle hysteresis timers
//   GATED_CNT_W   : width of the optional gated-cycle statistics counter
//   WAKE_CNT_W    : width of the optional wake-event statistics counter
// -----------------------------------------------------------------------------
package gated_counter_sched_pkg;

   typedef enum logic [1:0] {
      GATED     = 2'd0,
      WAKE      = 2'd1,
      ACTIVE    = 2'd2,
      IDLE_HOLD = 2'd3
   } sched_state_e;

   localparam int TIMER_W     = 4;
   localparam int GATED_CNT_W = 16;
   localparam int WAKE_CNT_W  = 8;

endpackage : gated_counter_sched_pkg

// File: rtl/gated_counter_scheduler_if.sv
// -----------------------------------------------------------------------------
// gated_counter_scheduler_if
// Bundle between requester logic and the scheduler.
//   req          : per-requester increment request (level, held until granted)
//   grant        : one-hot grant pulse, one cycle per granted increment
//   gate_en      : enable for the counter's clock gating cell
//   inc_pulse    : increment strobe to the counter (== |grant)
//   busy         : scheduler is not in GATED
//   state_o      : current state encoding, debug only
//   gated_cycles : cycles spent in GATED, saturating  (GATE_STATS_EN only)
//   wake_events  : GATED->WAKE transitions, wrapping  (GATE_STATS_EN only)
// Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface gated_counter_scheduler_if #(
   parameter int NUM_REQ = 4
);
   import gated_counter_sched_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] grant;
   logic               gate_en;
   logic               inc_pulse;
   logic               busy;
   logic [1:0]         state_o;

`ifdef GATE_STATS_EN
   logic [GATED_CNT_W-1:0] gated_cycles;
   logic [WAKE_CNT_W-1:0]  wake_events;

   modport master (
      output req,
      input  grant, gate_en, inc_pulse, busy, state_o, gated_cycles, wake_events
   );
   modport slave (
      input  req,
      output grant, gate_en, inc_pulse, busy, state_o, gated_cycles, wake_events
   );
`else
   modport master (
      output req,
      input  grant, gate_en, inc_pulse, busy, state_o
   );
   modport slave (
      input  req,
      output grant, gate_en, inc_pulse, busy, state_o
   );
`endif

endinterface : gated_counter_scheduler_if

// File: rtl/gated_counter_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches req_i starting at ptr_i
// and wrapping, grants the first asserted requester.
//   req_i      : request vector
//   ptr_i      : index with highest priority this cycle
//   en_i       : arbitration enable; grant_o is zero when low
//   grant_o    : one-hot grant (zero if disabled or no request)
//   next_ptr_o : index after the granted one (mod NUM_REQ), else ptr_i
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [PTR_W-1:0]   next_ptr_o
);

   logic found;
   int   idx;

   always_comb begin
      // NOTE: every output gets a default before any branch so no path leaves
      // it unassigned, otherwise synthesis infers a latch.
      grant_o    = '0;
      next_ptr_o = ptr_i;
      found      = 1'b0;
      idx        = 0;
      if (en_i) begin
         for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_i[idx]) begin
               found        = 1'b1;
               grant_o[idx] = 1'b1;
               next_ptr_o   = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/gated_counter_scheduler.sv
// -----------------------------------------------------------------------------
// gated_counter_scheduler
// Shares one clock-gated 4-bit counter among NUM_REQ requesters: opens the
// counter's clock gate on demand, waits WAKE_CYCLES for the clock to settle,
// round-robin grants one increment per cycle, and closes the gate after
// IDLE_CYCLES request-free cycles.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : gated_counter_scheduler_if.slave (req in; grant, gate_en,
//           inc_pulse, busy, state_o out)
// Optional feature (macro GATE_STATS_EN): adds bus.gated_cycles (saturating
// count of GATED cycles) and bus.wake_events (wrapping count of wake-ups).
// -----------------------------------------------------------------------------
module gated_counter_scheduler
   import gated_counter_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int IDLE_CYCLES = 4,
   parameter int WAKE_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   gated_counter_scheduler_if.slave  bus
);

   localparam int PTR_W = $clog2(NUM_REQ);

   sched_state_e       state_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [TIMER_W-1:0] idle_q;
   logic [TIMER_W-1:0] wake_q;
   logic [NUM_REQ-1:0] grant_q;
   logic               gate_en_q;
   logic               inc_pulse_q;

   logic [NUM_REQ-1:0] arb_grant;
   logic [PTR_W-1:0]   arb_next_ptr;
   logic               any_req;

   assign any_req = |bus.req;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i      (bus.req),
      .ptr_i      (ptr_q),
      .en_i       (state_q == ACTIVE),
      .grant_o    (arb_grant),
      .next_ptr_o (arb_next_ptr)
   );

   // Grants are only arbitrated in ACTIVE, and ACTIVE never leads straight to
   // GATED, so the gate is still open in the cycle the registered grant shows.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q     <= GATED;
         ptr_q       <= '0;
         idle_q      <= '0;
         wake_q      <= '0;
         grant_q     <= '0;
         gate_en_q   <= 1'b0;
         inc_pulse_q <= 1'b0;
      end else begin
         grant_q     <= '0;
         inc_pulse_q <= 1'b0;
         unique case (state_q)
            GATED: begin
               if (any_req) begin
                  state_q   <= WAKE;
                  wake_q    <= TIMER_W'(WAKE_CYCLES - 1);
                  gate_en_q <= 1'b1;
               end
            end
            WAKE: begin
               // Requests dropping here are ignored; IDLE_HOLD handles it.
               if (wake_q == '0) state_q <= ACTIVE;
               else              wake_q  <= wake_q - 1'b1;
            end
            ACTIVE: begin
               if (any_req) begin
                  grant_q     <= arb_grant;
                  inc_pulse_q <= 1'b1;
                  ptr_q       <= arb_next_ptr;
               end else begin
                  state_q <= IDLE_HOLD;
                  idle_q  <= TIMER_W'(IDLE_CYCLES - 1);
               end
            end
            IDLE_HOLD: begin
               // A request on the expiry cycle wins over closing the gate.
               if (any_req) begin
                  state_q <= ACTIVE;
               end else if (idle_q == '0) begin
                  state_q   <= GATED;
                  gate_en_q <= 1'b0;
               end else begin
                  idle_q <= idle_q - 1'b1;
               end
            end
            default: state_q <= GATED;
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.gate_en   = gate_en_q;
   assign bus.inc_pulse = inc_pulse_q;
   assign bus.busy      = (state_q != GATED);
   assign bus.state_o   = state_q;

`ifdef GATE_STATS_EN
   logic [GATED_CNT_W-1:0] gated_cycles_q;
   logic [WAKE_CNT_W-1:0]  wake_events_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gated_cycles_q <= '0;
         wake_events_q  <= '0;
      end else begin
         if (state_q == GATED && gated_cycles_q != '1)
            gated_cycles_q <= gated_cycles_q + 1'b1;
         // Wraps naturally at 8 bits.
         if (state_q == GATED && any_req)
            wake_events_q <= wake_events_q + 1'b1;
      end
   end

   assign bus.gated_cycles = gated_cycles_q;
   assign bus.wake_events  = wake_events_q;
`endif

endmodule : gated_counter_scheduler
